// File: rtl/hazard_stall_unit_pkg.sv
// Shared ISA constants, field slices and Tuse/Tnew encodings
// for the decode-stage hazard logic.
package hazard_stall_unit_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] tnew;
  } stage_t;

  function automatic logic [5:0] f_op(
    input logic [31:0] ir
  );
    return ir[31:26];
  endfunction

  function automatic logic [5:0] f_fn(
    input logic [31:0] ir
  );
    return ir[5:0];
  endfunction

  function automatic logic [4:0] f_rs(
    input logic [31:0] ir
  );
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(
    input logic [31:0] ir
  );
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(
    input logic [31:0] ir
  );
    return ir[15:11];
  endfunction

  function automatic logic [1:0] sat_dec(
    input logic [1:0] t
  );
    return (t == T0) ? T0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_instr_class_decode.sv
// Instruction class decode: operand Tuse and result A3/Tnew
// for the instruction held in a pipeline register.
module instr_class_decode
  import hazard_stall_unit_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [1:0]  o_tuse_rs,
  output logic [1:0]  o_tuse_rt,
  output logic        o_use_rs,
  output logic        o_use_rt,
  output logic [4:0]  o_a3,
  output logic [1:0]  o_tnew
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic       w_r;
  logic       w_alu_r;
  logic       w_jr;
  logic       w_unused_shamt;

  assign w_op    = f_op(i_ir);
  assign w_fn    = f_fn(i_ir);
  assign w_r     = (w_op == OP_R);
  assign w_alu_r = w_r & ((w_fn == FN_ADDU) | (w_fn == FN_SUBU));
  assign w_jr    = w_r & (w_fn == FN_JR);
  assign w_unused_shamt = ^i_ir[10:6];

  always_comb begin
    o_tuse_rs = T0;
    o_tuse_rt = T0;
    o_use_rs  = 1'b0;
    o_use_rt  = 1'b0;
    o_a3      = 5'd0;
    o_tnew    = T0;
    unique case (1'b1)
      w_alu_r: begin
        o_use_rs  = 1'b1;
        o_tuse_rs = T1;
        o_use_rt  = 1'b1;
        o_tuse_rt = T1;
        o_a3      = f_rd(i_ir);
        o_tnew    = T1;
      end
      w_jr: begin
        o_use_rs  = 1'b1;
        o_tuse_rs = T0;
      end
      (w_op == OP_ORI): begin
        o_use_rs  = 1'b1;
        o_tuse_rs = T1;
        o_a3      = f_rt(i_ir);
        o_tnew    = T1;
      end
      (w_op == OP_LW): begin
        o_use_rs  = 1'b1;
        o_tuse_rs = T1;
        o_a3      = f_rt(i_ir);
        o_tnew    = T2;
      end
      (w_op == OP_SW): begin
        o_use_rs  = 1'b1;
        o_tuse_rs = T1;
        o_use_rt  = 1'b1;
        o_tuse_rt = T2;
      end
      (w_op == OP_BEQ): begin
        o_use_rs  = 1'b1;
        o_tuse_rs = T0;
        o_use_rt  = 1'b1;
        o_tuse_rt = T0;
      end
      (w_op == OP_LUI): begin
        o_a3   = f_rt(i_ir);
        o_tnew = T1;
      end
      (w_op == OP_JAL): begin
        o_a3   = REG_RA;
        o_tnew = T0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Decode-stage stall controller: shadows A3/Tnew of E/M/W and
// stalls D when forwarding cannot satisfy an operand in time.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            IR_D,
  input  logic                   freeze,
  output logic                   stall,
  output logic                   flush_E,
  output logic [4:0]             A3_E,
  output logic [4:0]             A3_M,
  output logic [4:0]             A3_W,
  output logic [1:0]             tnew_E,
  output logic [1:0]             tnew_M,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [1:0] w_tuse_rs;
  logic [1:0] w_tuse_rt;
  logic       w_use_rs;
  logic       w_use_rt;
  logic [4:0] w_a3_d;
  logic [1:0] w_tnew_d;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_stall_rs;
  logic       w_stall_rt;

  stage_t r_e;
  stage_t r_m;
  logic [4:0] r_a3_w;
  logic [STALL_CNT_W-1:0] r_cnt;

  instr_class_decode u_dec (
    .i_ir      (IR_D),
    .o_tuse_rs (w_tuse_rs),
    .o_tuse_rt (w_tuse_rt),
    .o_use_rs  (w_use_rs),
    .o_use_rt  (w_use_rt),
    .o_a3      (w_a3_d),
    .o_tnew    (w_tnew_d)
  );

  assign w_rs = f_rs(IR_D);
  assign w_rt = f_rt(IR_D);

  // $0 is never a real producer, so a zero source can't stall
  assign w_stall_rs = w_use_rs & (w_rs != 5'd0) &
    (((w_rs == r_e.a3) & (w_tuse_rs < r_e.tnew)) |
     ((w_rs == r_m.a3) & (w_tuse_rs < r_m.tnew)));

  assign w_stall_rt = w_use_rt & (w_rt != 5'd0) &
    (((w_rt == r_e.a3) & (w_tuse_rt < r_e.tnew)) |
     ((w_rt == r_m.a3) & (w_tuse_rt < r_m.tnew)));

  assign stall   = w_stall_rs | w_stall_rt;
  assign flush_E = stall & ~freeze;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e    <= '0;
      r_m    <= '0;
      r_a3_w <= 5'd0;
      r_cnt  <= '0;
    end else if (!freeze) begin
      if (stall) begin
        r_e <= '0;
      end else begin
        r_e.a3   <= w_a3_d;
        r_e.tnew <= w_tnew_d;
      end
      r_m.a3   <= r_e.a3;
      r_m.tnew <= sat_dec(r_e.tnew);
      r_a3_w   <= r_m.a3;
      if (stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign A3_E      = r_e.a3;
  assign A3_M      = r_m.a3;
  assign A3_W      = r_a3_w;
  assign tnew_E    = r_e.tnew;
  assign tnew_M    = r_m.tnew;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed vector bench for hazard_stall_unit, plus freeze
// and asynchronous-reset sequences.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] IR_D = 32'd0;
  logic        freeze = 1'b0;
  logic        stall, flush_E;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic [1:0]  tnew_E, tnew_M;
  logic [31:0] stall_cnt;
  logic        stall2, flush2;
  logic [4:0]  a3e2, a3m2, a3w2;
  logic [1:0]  te2, tm2;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .reset_n(reset_n), .IR_D(IR_D), .freeze(freeze),
    .stall(stall), .flush_E(flush_E),
    .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W),
    .tnew_E(tnew_E), .tnew_M(tnew_M), .stall_cnt(stall_cnt)
  );

  hazard_stall_unit #(.STALL_CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .IR_D(IR_D), .freeze(freeze),
    .stall(stall2), .flush_E(flush2),
    .A3_E(a3e2), .A3_M(a3m2), .A3_W(a3w2),
    .tnew_E(te2), .tnew_M(tm2), .stall_cnt(cnt2)
  );

  function automatic logic [31:0] enc_i(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rt, input logic [4:0] rs);
    return enc_i(6'h23, rs, rt, 16'd0);
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rt, input logic [4:0] rs);
    return enc_i(6'h2b, rs, rt, 16'd0);
  endfunction
  function automatic logic [31:0] beq(input logic [4:0] rs, input logic [4:0] rt);
    return enc_i(6'h04, rs, rt, 16'd3);
  endfunction
  function automatic logic [31:0] ori(input logic [4:0] rt, input logic [4:0] rs);
    return enc_i(6'h0d, rs, rt, 16'd5);
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rt);
    return enc_i(6'h0f, 5'd0, rt, 16'h1234);
  endfunction
  function automatic logic [31:0] addu(input logic [4:0] rd,
    input logic [4:0] rs, input logic [4:0] rt);
    return enc_r(rs, rt, rd, 6'h21);
  endfunction
  function automatic logic [31:0] subu(input logic [4:0] rd,
    input logic [4:0] rs, input logic [4:0] rt);
    return enc_r(rs, rt, rd, 6'h23);
  endfunction
  function automatic logic [31:0] jr(input logic [4:0] rs);
    return enc_r(rs, 5'd0, 5'd0, 6'h08);
  endfunction

  localparam logic [31:0] NOP = 32'd0;
  localparam logic [31:0] JAL = 32'h0C000010;
  localparam logic [31:0] JMP = 32'h08000020;

  typedef struct {
    logic [31:0] ir;
    logic        st;
    logic [4:0]  ae, am, aw;
    logic [1:0]  te, tm;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [31:0] ir, input logic st,
    input logic [4:0] ae, input logic [1:0] te,
    input logic [4:0] am, input logic [1:0] tm,
    input logic [4:0] aw, input int cnt);
    vec_t v;
    v.ir = ir; v.st = st; v.ae = ae; v.te = te;
    v.am = am; v.tm = tm; v.aw = aw; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
    input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic st,
    input logic fl, input logic [4:0] ae, input logic [1:0] te,
    input logic [4:0] am, input logic [1:0] tm,
    input logic [4:0] aw, input int cnt);
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, st});
    chk({tag, ".flush_E"}, {31'd0, flush_E}, {31'd0, fl});
    chk({tag, ".A3_E"}, {27'd0, A3_E}, {27'd0, ae});
    chk({tag, ".tnew_E"}, {30'd0, tnew_E}, {30'd0, te});
    chk({tag, ".A3_M"}, {27'd0, A3_M}, {27'd0, am});
    chk({tag, ".tnew_M"}, {30'd0, tnew_M}, {30'd0, tm});
    chk({tag, ".A3_W"}, {27'd0, A3_W}, {27'd0, aw});
    chk({tag, ".stall_cnt"}, stall_cnt, cnt);
    chk({tag, ".sat_cnt"}, {30'd0, cnt2}, (cnt > 3) ? 32'd3 : cnt);
  endtask

  task automatic drive(input logic [31:0] ir, input logic frz);
    @(negedge clk);
    IR_D = ir;
    freeze = frz;
    #1;
  endtask

  initial begin
    // ir, stall, A3_E, tnew_E, A3_M, tnew_M, A3_W, stall_cnt
    add(lw(1, 0),          0, 0, 0, 0, 0, 0, 0);
    add(addu(2, 1, 1),     1, 1, 2, 0, 0, 0, 0);
    add(addu(2, 1, 1),     0, 0, 0, 1, 1, 0, 1);
    add(NOP,               0, 2, 1, 0, 0, 1, 1);
    add(NOP,               0, 0, 0, 2, 0, 0, 1);
    add(NOP,               0, 0, 0, 0, 0, 2, 1);
    add(lw(1, 0),          0, 0, 0, 0, 0, 0, 1);
    add(beq(1, 0),         1, 1, 2, 0, 0, 0, 1);
    add(beq(1, 0),         1, 0, 0, 1, 1, 0, 2);
    add(beq(1, 0),         0, 0, 0, 0, 0, 1, 3);
    add(NOP,               0, 0, 0, 0, 0, 0, 3);
    add(ori(1, 0),         0, 0, 0, 0, 0, 0, 3);
    add(beq(1, 0),         1, 1, 1, 0, 0, 0, 3);
    add(beq(1, 0),         0, 0, 0, 1, 0, 0, 4);
    add(ori(0, 0),         0, 0, 0, 0, 0, 1, 4);
    add(beq(0, 0),         0, 0, 1, 0, 0, 0, 4);
    add(NOP,               0, 0, 0, 0, 0, 0, 4);
    add(JAL,               0, 0, 0, 0, 0, 0, 4);
    add(jr(31),            0, 31, 0, 0, 0, 0, 4);
    add(lw(3, 0),          0, 0, 0, 31, 0, 0, 4);
    add(sw(3, 0),          0, 3, 2, 0, 0, 31, 4);
    add(NOP,               0, 0, 0, 3, 1, 0, 4);
    add(NOP,               0, 0, 0, 0, 0, 3, 4);
    add(lw(4, 0),          0, 0, 0, 0, 0, 0, 4);
    add(sw(5, 4),          1, 4, 2, 0, 0, 0, 4);
    add(sw(5, 4),          0, 0, 0, 4, 1, 0, 5);
    add(NOP,               0, 0, 0, 0, 0, 4, 5);
    add(lui(6),            0, 0, 0, 0, 0, 0, 5);
    add(JMP,               0, 6, 1, 0, 0, 0, 5);
    add(subu(7, 6, 6),     0, 0, 0, 6, 0, 0, 5);
    add(NOP,               0, 7, 1, 0, 0, 6, 5);
    add(NOP,               0, 0, 0, 7, 0, 0, 5);
    add(NOP,               0, 0, 0, 0, 0, 7, 5);
    add(NOP,               0, 0, 0, 0, 0, 0, 5);

    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].ir, 1'b0);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].st,
        tbl[i].ae, tbl[i].te, tbl[i].am, tbl[i].tm,
        tbl[i].aw, tbl[i].cnt);
    end

    // freeze held with a load-use pair pending
    drive(lw(1, 0), 1'b0);
    chk_all("frz_lw", 0, 0, 0, 0, 0, 0, 0, 5);
    for (int k = 0; k < 3; k++) begin
      drive(addu(2, 1, 1), 1'b1);
      chk_all($sformatf("frz%0d", k), 1, 0, 1, 2, 0, 0, 0, 5);
    end
    drive(addu(2, 1, 1), 1'b0);
    chk_all("frz_rel", 1, 1, 1, 2, 0, 0, 0, 5);
    drive(addu(2, 1, 1), 1'b0);
    chk_all("frz_go", 0, 0, 0, 0, 1, 1, 0, 6);
    for (int k = 0; k < 3; k++) drive(NOP, 1'b0);

    // asynchronous reset in the middle of a 2-cycle beq stall
    drive(lw(1, 0), 1'b0);
    chk_all("rst_lw", 0, 0, 0, 0, 0, 0, 0, 6);
    drive(beq(1, 0), 1'b0);
    chk_all("rst_s1", 1, 1, 1, 2, 0, 0, 0, 6);
    drive(beq(1, 0), 1'b0);
    chk_all("rst_s2", 1, 1, 0, 0, 1, 1, 0, 7);
    #1;
    reset_n = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_all("rst_rel", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(addu(2, 1, 1), 1'b0);
    chk_all("rst_next", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
